// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII helpers for the UART hex command receiver.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    P_IDLE,
    P_ADDR,
    P_SPACE,
    P_DATA,
    P_CR,
    P_HOLD,
    P_DISCARD
  } parse_state_t;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_W  = 8'h57;
  localparam logic [7:0] CH_R  = 8'h52;

  // Returns {valid, nibble}; valid is 0 for anything that is not a hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] ch);
    logic [4:0] res;
    res = 5'b0;
    if (ch >= 8'h30 && ch <= 8'h39)
      res = {1'b1, 4'(ch - 8'h30)};
    else if (ch >= 8'h41 && ch <= 8'h46)
      res = {1'b1, 4'(ch - 8'h37)};
    else if (ch >= 8'h61 && ch <= 8'h66)
      res = {1'b1, 4'(ch - 8'h57)};
    return res;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling, framing check.
module uart_byte_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       greset,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  rx_state_t   state, state_n;
  logic        sync0, sync1, rx_prev;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shift, shift_n;
  logic        byte_valid_n, frame_err_n;

  always_ff @(posedge clk) begin
    if (!greset) begin
      sync0      <= 1'b1;
      sync1      <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= IDLE;
      cnt        <= 16'd0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync0      <= uart_rx;
      sync1      <= sync0;
      rx_prev    <= sync1;
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      byte_valid <= byte_valid_n;
      frame_err  <= frame_err_n;
    end
  end

  // A start needs a real 1->0 edge, so after a framing error the line must
  // go idle again before the next byte is accepted.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt + 16'd1;
    bit_n        = bit_idx;
    shift_n      = shift;
    byte_valid_n = 1'b0;
    frame_err_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = 16'd0;
        if (rx_prev && !sync1)
          state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          if (sync1) begin
            state_n = IDLE;
          end else begin
            cnt_n   = 16'd0;
            bit_n   = 3'd0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n   = 16'd0;
          shift_n = {sync1, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7)
            state_n = STOP;
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          state_n = IDLE;
          if (sync1)
            byte_valid_n = 1'b1;
          else
            frame_err_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign byte_data = shift;

endmodule

// File: rtl/uart_cmd_rx.sv
// UART hex command parser ("Waaaa dd\r" / "Raaaa\r") driving a valid/ready request.
// Read commands are only accepted when UART_CMD_READ_EN is defined.
module uart_cmd_rx
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              greset,
  input  logic              uart_rx,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_data,
  output logic              err
);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_rx (
    .clk       (clk),
    .greset    (greset),
    .uart_rx   (uart_rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  parse_state_t state, state_n;
  logic [1:0]   cnt, cnt_n;
  logic [15:0]  addr_sh, addr_n;
  logic [7:0]   data_sh, data_n;
  logic         is_write, write_n;
  logic         ovr, ovr_n;
  logic         valid_n, load, syn_err, ovr_err;
  logic [4:0]   hex;

  always_ff @(posedge clk) begin
    if (!greset) begin
      state     <= P_IDLE;
      cnt       <= 2'd0;
      addr_sh   <= 16'd0;
      data_sh   <= 8'd0;
      is_write  <= 1'b0;
      ovr       <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= 8'd0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      addr_sh   <= addr_n;
      data_sh   <= data_n;
      is_write  <= write_n;
      ovr       <= ovr_n;
      cmd_valid <= valid_n;
      err       <= syn_err | ovr_err | frame_err;
      if (load) begin
        cmd_addr <= ADDR_W'(addr_sh);
        cmd_data <= is_write ? data_sh : 8'h00;
      end
    end
  end

`ifdef UART_CMD_READ_EN
  always_ff @(posedge clk) begin
    if (!greset)
      cmd_write <= 1'b0;
    else if (load)
      cmd_write <= is_write;
  end
`else
  assign cmd_write = 1'b1;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr_sh;
    data_n  = data_sh;
    write_n = is_write;
    ovr_n   = ovr;
    valid_n = cmd_valid;
    load    = 1'b0;
    syn_err = 1'b0;
    ovr_err = 1'b0;
    hex     = hex_val(byte_data);
    case (state)
      P_IDLE: begin
        if (byte_valid) begin
          if ((byte_data | 8'h20) == (CH_W | 8'h20)) begin
            write_n = 1'b1;
            addr_n  = 16'd0;
            data_n  = 8'd0;
            cnt_n   = 2'd0;
            state_n = P_ADDR;
          end
`ifdef UART_CMD_READ_EN
          else if ((byte_data | 8'h20) == (CH_R | 8'h20)) begin
            write_n = 1'b0;
            addr_n  = 16'd0;
            data_n  = 8'd0;
            cnt_n   = 2'd0;
            state_n = P_ADDR;
          end
`endif
          else if (byte_data != CH_CR && byte_data != CH_LF) begin
            syn_err = 1'b1;
          end
        end
      end
      P_ADDR: begin
        if (byte_valid) begin
          if (hex[4]) begin
            addr_n = {addr_sh[11:0], hex[3:0]};
            cnt_n  = cnt + 2'd1;
            if (cnt == 2'd3)
              state_n = is_write ? P_SPACE : P_CR;
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      P_SPACE: begin
        if (byte_valid) begin
          if (byte_data == CH_SP) begin
            cnt_n   = 2'd0;
            state_n = P_DATA;
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      P_DATA: begin
        if (byte_valid) begin
          if (hex[4]) begin
            data_n = {data_sh[3:0], hex[3:0]};
            cnt_n  = cnt + 2'd1;
            if (cnt == 2'd1)
              state_n = P_CR;
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      P_CR: begin
        if (byte_valid) begin
          if (byte_data == CH_CR) begin
            load    = 1'b1;
            valid_n = 1'b1;
            ovr_n   = 1'b0;
            state_n = P_HOLD;
          end else begin
            syn_err = 1'b1;
          end
        end
      end
      P_HOLD: begin
        // Only the first dropped byte per held command raises err.
        if (byte_valid) begin
          ovr_err = !ovr;
          ovr_n   = 1'b1;
        end
        if (cmd_valid && cmd_ready) begin
          valid_n = 1'b0;
          state_n = ovr_n ? P_DISCARD : P_IDLE;
          ovr_n   = 1'b0;
        end
      end
      P_DISCARD: begin
        if (byte_valid && byte_data == CH_CR)
          state_n = P_IDLE;
      end
      default: state_n = P_IDLE;
    endcase
    // A CR that breaks the grammar already ends the line, so nothing to discard.
    if (syn_err)
      state_n = (byte_data == CH_CR) ? P_IDLE : P_DISCARD;
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at 16 clocks per bit; honours UART_CMD_READ_EN.
module tb_uart_cmd_rx;

  localparam int CLKS = 16;

  logic        clk = 1'b0;
  logic        greset;
  logic        uart_rx;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        err;

  int          total = 0;
  int          bad = 0;
  int          xfer_cnt = 0;
  int          err_cnt = 0;
  int          xfer_base;
  int          err_base;
  logic [15:0] last_addr = 16'hxxxx;
  logic [7:0]  last_data = 8'hxx;
  logic        last_write = 1'bx;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CLKS),
    .ADDR_W      (16)
  ) dut (
    .clk      (clk),
    .greset   (greset),
    .uart_rx  (uart_rx),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Records every accepted transfer and every err pulse outside reset.
  always @(negedge clk) begin
    if (greset === 1'b1) begin
      if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
        xfer_cnt   = xfer_cnt + 1;
        last_addr  = cmd_addr;
        last_data  = cmd_data;
        last_write = cmd_write;
      end
      if (err === 1'b1)
        err_cnt = err_cnt + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected)
    else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_cycles(CLKS);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_cycles(CLKS);
    end
    uart_rx = stop_bit;
    wait_cycles(CLKS);
    uart_rx = 1'b1;
    wait_cycles(4);
  endtask

  task automatic send_line(input string s);
    for (int i = 0; i < s.len(); i++)
      applyStimulus(s[i], 1'b1);
    applyStimulus(8'h0D, 1'b1);
    wait_cycles(2 * CLKS);
  endtask

  task automatic snap();
    xfer_base = xfer_cnt;
    err_base  = err_cnt;
  endtask

  initial begin
    greset    = 1'b0;
    uart_rx   = 1'b1;
    cmd_ready = 1'b1;
    wait_cycles(5);
    @(negedge clk);
    checkOutput("rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("rst_addr", 32'(cmd_addr), 32'd0);
    checkOutput("rst_data", 32'(cmd_data), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
`ifdef UART_CMD_READ_EN
    checkOutput("rst_write", 32'(cmd_write), 32'd0);
`else
    checkOutput("rst_write", 32'(cmd_write), 32'd1);
`endif
    wait_cycles(1);
    greset = 1'b1;
    wait_cycles(CLKS);

    $display("[TB] basic write");
    snap();
    send_line("W8123 A5");
    checkOutput("w1_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
    checkOutput("w1_addr", 32'(last_addr), 32'h8123);
    checkOutput("w1_data", 32'(last_data), 32'hA5);
    checkOutput("w1_write", 32'(last_write), 32'd1);
    checkOutput("w1_err", 32'(err_cnt - err_base), 32'd0);
    @(negedge clk);
    checkOutput("w1_valid_low", 32'(cmd_valid), 32'd0);

    $display("[TB] read command");
    snap();
    send_line("r00ff");
`ifdef UART_CMD_READ_EN
    checkOutput("rd_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
    checkOutput("rd_write", 32'(last_write), 32'd0);
    checkOutput("rd_addr", 32'(last_addr), 32'h00FF);
    checkOutput("rd_data", 32'(last_data), 32'h00);
    checkOutput("rd_err", 32'(err_cnt - err_base), 32'd0);
`else
    checkOutput("rd_xfer", 32'(xfer_cnt - xfer_base), 32'd0);
    checkOutput("rd_err", 32'(err_cnt - err_base), 32'd1);
`endif

    $display("[TB] bad hex digit then recovery");
    snap();
    send_line("W12G4 00");
    checkOutput("syn_err", 32'(err_cnt - err_base), 32'd1);
    checkOutput("syn_xfer", 32'(xfer_cnt - xfer_base), 32'd0);
    snap();
    send_line("W0001 01");
    checkOutput("rec_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
    checkOutput("rec_addr", 32'(last_addr), 32'h0001);
    checkOutput("rec_data", 32'(last_data), 32'h01);
    checkOutput("rec_err", 32'(err_cnt - err_base), 32'd0);

    $display("[TB] framing error");
    snap();
    applyStimulus(8'h57, 1'b0);
    wait_cycles(2 * CLKS);
    checkOutput("frm_err", 32'(err_cnt - err_base), 32'd1);
    // If the 'W' had leaked through, this line would issue 1234/56.
    send_line("1234 56");
    checkOutput("frm_err2", 32'(err_cnt - err_base), 32'd2);
    checkOutput("frm_xfer", 32'(xfer_cnt - xfer_base), 32'd0);

    $display("[TB] start glitch");
    snap();
    uart_rx = 1'b0;
    wait_cycles(3);
    uart_rx = 1'b1;
    wait_cycles(3 * CLKS);
    checkOutput("glt_err", 32'(err_cnt - err_base), 32'd0);
    send_line("W0002 02");
    checkOutput("glt_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
    checkOutput("glt_addr", 32'(last_addr), 32'h0002);
    checkOutput("glt_err2", 32'(err_cnt - err_base), 32'd0);

    $display("[TB] overrun while holding");
    cmd_ready = 1'b0;
    snap();
    send_line("W4000 11");
    @(negedge clk);
    checkOutput("hold_valid", 32'(cmd_valid), 32'd1);
    checkOutput("hold_addr", 32'(cmd_addr), 32'h4000);
    checkOutput("hold_data", 32'(cmd_data), 32'h11);
    send_line("W5000 22");
    @(negedge clk);
    checkOutput("ovr_err", 32'(err_cnt - err_base), 32'd1);
    checkOutput("ovr_valid", 32'(cmd_valid), 32'd1);
    checkOutput("ovr_addr", 32'(cmd_addr), 32'h4000);
    checkOutput("ovr_data", 32'(cmd_data), 32'h11);
    checkOutput("ovr_noxfer", 32'(xfer_cnt - xfer_base), 32'd0);
    wait_cycles(1);
    cmd_ready = 1'b1;
    wait_cycles(3);
    checkOutput("ovr_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
    checkOutput("ovr_xaddr", 32'(last_addr), 32'h4000);
    checkOutput("ovr_xdata", 32'(last_data), 32'h11);
    @(negedge clk);
    checkOutput("ovr_drop", 32'(cmd_valid), 32'd0);
    wait_cycles(4 * CLKS);
    checkOutput("ovr_no5000", 32'(xfer_cnt - xfer_base), 32'd1);

    $display("[TB] reset mid-command");
    applyStimulus(8'h57, 1'b1);
    applyStimulus(8'h38, 1'b1);
    applyStimulus(8'h30, 1'b1);
    uart_rx = 1'b0;
    wait_cycles(40);
    greset  = 1'b0;
    uart_rx = 1'b1;
    wait_cycles(4);
    @(negedge clk);
    checkOutput("mid_rst_valid", 32'(cmd_valid), 32'd0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    wait_cycles(1);
    greset = 1'b1;
    wait_cycles(4);
    snap();
    send_line("W9000 33");
    checkOutput("post_xfer", 32'(xfer_cnt - xfer_base), 32'd1);
    checkOutput("post_addr", 32'(last_addr), 32'h9000);
    checkOutput("post_data", 32'(last_data), 32'h33);
    checkOutput("post_err", 32'(err_cnt - err_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
